// File: rtl/ctrl_pipe_stage.sv
// Control-path pipeline for a 5-stage CPU: stages the decoder's control bundle
// through ID/EX, EX/MEM and MEM/WB, detects load-use hazards and selects EX forwarding.
module ctrl_pipe_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RA_W-1:0]   rs_id_i,
  input  logic [RA_W-1:0]   rt_id_i,
  input  logic [RA_W-1:0]   rd_id_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_alusrc_o,
  output logic [1:0]        ex_aluop_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_regwrite_o,
  output logic [RA_W-1:0]   mem_wreg_o,
  output logic              wb_regwrite_o,
  output logic              wb_memtoreg_o,
  output logic [RA_W-1:0]   wb_wreg_o
);

  localparam int unsigned MEM_CTRL_W = 4;
  localparam int unsigned WB_CTRL_W  = 2;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Decoded control bundle layout
  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  ctrl_t           ex_ctrl;
  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic [RA_W-1:0] ex_rd;
  logic [RA_W-1:0] ex_wreg;

  mem_ctrl_t       mem_ctrl;
  wb_ctrl_t        wb_ctrl;
  logic            bubble;

  assign ex_wreg = ex_ctrl.reg_dst ? ex_rt : ex_rd;
  assign bubble  = stall_o | flush_i;

  // Load-use hazard: the load in EX writes a register the ID instruction reads
  always_comb begin
    stall_o = 1'b0;
    if (ex_ctrl.mem_read && (ex_wreg != '0) &&
        ((ex_wreg == rs_id_i) || (ex_wreg == rt_id_i))) begin
      stall_o = 1'b1;
    end
  end

  // ID/EX register; a stall or flush inserts an all-zero bubble
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else if (bubble) begin
      ex_ctrl <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else begin
      ex_ctrl <= ctrl_t'(ctrl_i[7:0]);
      ex_rs   <= rs_id_i;
      ex_rt   <= rt_id_i;
      ex_rd   <= rd_id_i;
    end
  end

  // EX/MEM register, never stalled
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_ctrl   <= '0;
      mem_wreg_o <= '0;
    end else begin
      mem_ctrl   <= mem_ctrl_t'(ex_ctrl[MEM_CTRL_W-1:0]);
      mem_wreg_o <= ex_wreg;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_ctrl   <= '0;
      wb_wreg_o <= '0;
    end else begin
      wb_ctrl   <= wb_ctrl_t'(mem_ctrl[WB_CTRL_W-1:0]);
      wb_wreg_o <= mem_wreg_o;
    end
  end

  assign ex_alusrc_o    = ex_ctrl.alu_src;
  assign ex_aluop_o     = ex_ctrl.alu_op;
  assign mem_read_o     = mem_ctrl.mem_read;
  assign mem_write_o    = mem_ctrl.mem_write;
  assign mem_regwrite_o = mem_ctrl.reg_write;
  assign wb_regwrite_o  = wb_ctrl.reg_write;
  assign wb_memtoreg_o  = wb_ctrl.mem_to_reg;

  // Forwarding selects; the younger EX/MEM result wins, r0 never forwards
  always_comb begin
    fwd_a_o = FWD_NONE;
    fwd_b_o = FWD_NONE;
    if (mem_ctrl.reg_write && (mem_wreg_o != '0) && (mem_wreg_o == ex_rs)) begin
      fwd_a_o = FWD_MEM;
    end else if (wb_ctrl.reg_write && (wb_wreg_o != '0) && (wb_wreg_o == ex_rs)) begin
      fwd_a_o = FWD_WB;
    end
    if (mem_ctrl.reg_write && (mem_wreg_o != '0) && (mem_wreg_o == ex_rt)) begin
      fwd_b_o = FWD_MEM;
    end else if (wb_ctrl.reg_write && (wb_wreg_o != '0) && (wb_wreg_o == ex_rt)) begin
      fwd_b_o = FWD_WB;
    end
  end

endmodule
